// File: rtl/div_seq_if.sv
// Request/result bundle between the EXE stage and the sequential divider.
// The divider takes the slave side; the EXE stage (or a bench) takes the master side.
interface div_seq_if;
    logic        div_valid;
    logic        div_signed;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        div_flush;
    logic        div_ready;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quot;
    logic [31:0] div_rem;

    modport master (
        output div_valid, div_signed, div_src1, div_src2, div_flush,
        input  div_ready, div_busy, div_done, div_quot, div_rem
    );

    modport slave (
        input  div_valid, div_signed, div_src1, div_src2, div_flush,
        output div_ready, div_busy, div_done, div_quot, div_rem
    );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle 32-bit restoring divider (DIV/DIVU) with flush.
// It produces one quotient bit per CALC cycle; the results register on the edge that enters DONE.
module div_seq #(
    parameter int ITER_N = 32
) (
    input  logic      clk,
    input  logic      resetn,
    div_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST_ITER = 5'(ITER_N - 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] rq_q, rq_d;
    logic [31:0] dvs_q, dvs_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;

    logic [32:0] diff_s;
    logic [63:0] step_s;
    logic        accept_s;
    logic        last_s;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? neg32(v) : v;
    endfunction

    assign accept_s = (state_q == S_IDLE) && bus.div_valid && !bus.div_flush;
    assign last_s   = (cnt_q == LAST_ITER);

    // One restoring step: a borrow on bit 32 means the divisor did not fit.
    always_comb begin
        diff_s = rq_q[63:31] - {1'b0, dvs_q};
        if (!diff_s[32]) begin
            step_s = {diff_s[31:0], rq_q[30:0], 1'b1};
        end else begin
            step_s = {rq_q[62:0], 1'b0};
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rq_d    = rq_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_CALC;
                    cnt_d   = 5'd0;
                    rq_d    = {32'd0, mag32(bus.div_src1, bus.div_signed)};
                    dvs_d   = mag32(bus.div_src2, bus.div_signed);
                    negq_d  = bus.div_signed && (bus.div_src1[31] ^ bus.div_src2[31]);
                    negr_d  = bus.div_signed && bus.div_src1[31];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (bus.div_flush) begin
                    state_d = S_IDLE;
                end else begin
                    rq_d  = step_s;
                    cnt_d = cnt_q + 5'd1;
                    if (last_s) begin
                        state_d = S_DONE;
                        // A zero divisor yields all-ones here, so the sign fix is skipped.
                        if (dvs_q == 32'd0) begin
                            quot_d = 32'hFFFF_FFFF;
                        end else begin
                            quot_d = negq_q ? neg32(step_s[31:0]) : step_s[31:0];
                        end
                        rem_d = negr_q ? neg32(step_s[63:32]) : step_s[63:32];
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            rq_q    <= 64'd0;
            dvs_q   <= 32'd0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            quot_q  <= 32'd0;
            rem_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rq_q    <= rq_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.div_ready = (state_q == S_IDLE);
    assign bus.div_busy  = (state_q == S_CALC);
    assign bus.div_done  = (state_q == S_DONE);
    assign bus.div_quot  = quot_q;
    assign bus.div_rem   = rem_q;
endmodule

// File: tb/tb_div_seq.sv
// Directed and random checks of div_seq against plain-arithmetic division.
// The bench samples outputs on the falling clock edge.
module tb_div_seq;
    logic clk;
    logic resetn;
    int   n_chk;
    int   n_pass;
    logic [31:0] last_q;
    logic [31:0] last_r;

    div_seq_if bus();

    div_seq #(.ITER_N(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // MIPS DIV/DIVU semantics: truncating division, remainder takes the dividend's sign.
    task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input int flush_at, input int rst_at, input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        int n;
        int busy_n;
        int done_at;
        int disturb;
        model(sgn, a, b, eq, er);
        @(negedge clk);
        bus.div_valid  = 1'b1;
        bus.div_signed = sgn;
        bus.div_src1   = a;
        bus.div_src2   = b;
        n = 0; busy_n = 0; done_at = 0; disturb = 0;
        while (n < 40 && done_at == 0) begin
            @(negedge clk);
            n++;
            if (hold) begin
                bus.div_src1   = $urandom;
                bus.div_src2   = $urandom;
                bus.div_signed = ~sgn;
            end else begin
                bus.div_valid = 1'b0;
            end
            busy_n += int'(bus.div_busy);
            if (bus.div_done) begin
                done_at = n;
                bus.div_valid = 1'b0;
            end else if (bus.div_quot !== last_q || bus.div_rem !== last_r) begin
                disturb++;
            end
            if (n == flush_at) begin
                bus.div_flush = 1'b1;
                bus.div_valid = 1'b0;
                @(negedge clk);
                bus.div_flush = 1'b0;
                chk({tag, "_flush_ready"}, 32'(bus.div_ready), 32'd1);
                chk({tag, "_flush_busy"},  32'(bus.div_busy),  32'd0);
                chk({tag, "_flush_done"},  32'(bus.div_done),  32'd0);
                chk({tag, "_flush_quot"},  bus.div_quot, last_q);
                chk({tag, "_flush_rem"},   bus.div_rem,  last_r);
                return;
            end
            if (n == rst_at) begin
                bus.div_valid = 1'b0;
                #2 resetn = 1'b0;
                #1;
                chk({tag, "_rst_ready"}, 32'(bus.div_ready), 32'd1);
                chk({tag, "_rst_busy"},  32'(bus.div_busy),  32'd0);
                chk({tag, "_rst_done"},  32'(bus.div_done),  32'd0);
                chk({tag, "_rst_quot"},  bus.div_quot, 32'd0);
                chk({tag, "_rst_rem"},   bus.div_rem,  32'd0);
                last_q = 32'd0;
                last_r = 32'd0;
                @(negedge clk);
                chk({tag, "_rst_nodone"}, 32'(bus.div_done), 32'd0);
                resetn = 1'b1;
                return;
            end
        end
        chk({tag, "_latency"}, 32'(done_at), 32'd33);
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd32);
        chk({tag, "_held_in_calc"}, 32'(disturb), 32'd0);
        chk({tag, "_quot"}, bus.div_quot, eq);
        chk({tag, "_rem"}, bus.div_rem, er);
        last_q = eq;
        last_r = er;
        @(negedge clk);
        chk({tag, "_ready_after"}, 32'(bus.div_ready), 32'd1);
        chk({tag, "_done_1cyc"},   32'(bus.div_done),  32'd0);
    endtask

    initial begin
        logic        rs;
        logic [31:0] ra;
        logic [31:0] rb;
        n_chk  = 0;
        n_pass = 0;
        last_q = 32'd0;
        last_r = 32'd0;
        resetn = 1'b0;
        bus.div_valid  = 1'b0;
        bus.div_signed = 1'b0;
        bus.div_src1   = 32'd0;
        bus.div_src2   = 32'd0;
        bus.div_flush  = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(bus.div_ready), 32'd1);
        chk("reset_busy",  32'(bus.div_busy),  32'd0);
        chk("reset_done",  32'(bus.div_done),  32'd0);
        chk("reset_quot",  bus.div_quot, 32'd0);
        chk("reset_rem",   bus.div_rem,  32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(bus.div_ready), 32'd1);

        run_op(1'b0, 32'd100, 32'd7, 1'b0, 0, 0, "u100_7");
        chk("u100_7_quot_lit", last_q, 32'd14);
        chk("u100_7_rem_lit",  last_r, 32'd2);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 0, "s_m7_2");
        chk("s_m7_2_quot_lit", last_q, 32'hFFFF_FFFD);
        chk("s_m7_2_rem_lit",  last_r, 32'hFFFF_FFFF);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 0, 0, "s_7_m2");
        chk("s_7_m2_rem_lit", last_r, 32'd1);
        run_op(1'b0, 32'h1234_5678, 32'd0, 1'b0, 0, 0, "u_div0");
        run_op(1'b1, 32'h1234_5678, 32'd0, 1'b0, 0, 0, "s_div0");
        run_op(1'b1, 32'hFEDC_BA98, 32'd0, 1'b0, 0, 0, "s_div0_neg");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0, "s_ovf");
        chk("s_ovf_quot_lit", last_q, 32'h8000_0000);

        run_op(1'b0, 32'd1000, 32'd3, 1'b0, 10, 0, "flush");
        run_op(1'b0, 32'd50, 32'd5, 1'b0, 0, 0, "after_flush");
        chk("after_flush_quot_lit", last_q, 32'd10);

        run_op(1'b0, 32'd999, 32'd10, 1'b1, 0, 0, "hold_valid");

        @(negedge clk);
        bus.div_valid = 1'b1;
        bus.div_flush = 1'b1;
        bus.div_src1  = 32'd77;
        bus.div_src2  = 32'd7;
        @(negedge clk);
        chk("vf_idle_busy",  32'(bus.div_busy),  32'd0);
        chk("vf_idle_ready", 32'(bus.div_ready), 32'd1);
        @(negedge clk);
        chk("vf_idle_busy2", 32'(bus.div_busy),  32'd0);
        bus.div_valid = 1'b0;
        bus.div_flush = 1'b0;

        run_op(1'b1, 32'hFFFF_0000, 32'd123, 1'b0, 0, 20, "reset_mid");
        run_op(1'b0, 32'd9, 32'd4, 1'b0, 0, 0, "after_reset");
        chk("after_reset_quot_lit", last_q, 32'd2);

        for (int i = 0; i < 12; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (i == 5) rb = 32'd0;
            run_op(rs, ra, rb, 1'b0, 0, 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
